// File: rtl/serial_number_transmitter.sv
// Serial number transmitter: accepts a W-bit word and shifts it out MSB first
// over a valid/ready bit stream. Alongside each bit it reports whether the
// prefix of the word sent so far, including the current bit, is divisible
// by 3 and by 5. Back-to-back words are accepted on the last-bit transfer
// so consecutive words stream without a bubble.
module serial_number_transmitter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic         out_bit,
    input  logic         out_ready,
    output logic         out_first,
    output logic         out_last,
    output logic         exp_div_by_3,
    output logic         exp_div_by_5
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(W - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [W-1:0]  word_r;
    logic [IW-1:0] idx_r;
    logic [1:0]    r3_r;
    logic [2:0]    r5_r;

    logic          bit_s;
    logic          first_s;
    logic          last_s;
    logic [1:0]    r3_next_s;
    logic [2:0]    r5_next_s;
    logic          xfer_s;
    logic          accept_s;

    // Remainder of (2*r + b) mod 3, with r already in 0..2.
    function automatic logic [1:0] mod3_step(input logic [1:0] r, input logic b);
        logic [1:0] res;
        case ({r, b})
            3'd0:    res = 2'd0;
            3'd1:    res = 2'd1;
            3'd2:    res = 2'd2;
            3'd3:    res = 2'd0;
            3'd4:    res = 2'd1;
            3'd5:    res = 2'd2;
            default: res = 2'd0;
        endcase
        return res;
    endfunction

    // Remainder of (2*r + b) mod 5, with r already in 0..4.
    function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
        logic [2:0] res;
        case ({r, b})
            4'd0:    res = 3'd0;
            4'd1:    res = 3'd1;
            4'd2:    res = 3'd2;
            4'd3:    res = 3'd3;
            4'd4:    res = 3'd4;
            4'd5:    res = 3'd0;
            4'd6:    res = 3'd1;
            4'd7:    res = 3'd2;
            4'd8:    res = 3'd3;
            4'd9:    res = 3'd4;
            default: res = 3'd0;
        endcase
        return res;
    endfunction

    // Current bit, position markers and the remainders after this bit.
    always_comb begin
        bit_s     = word_r[idx_r];
        first_s   = (idx_r == IDX_TOP);
        last_s    = (idx_r == {IW{1'b0}});
        r3_next_s = mod3_step(r3_r, bit_s);
        r5_next_s = mod5_step(r5_r, bit_s);
    end

    assign xfer_s   = out_valid & out_ready;
    assign accept_s = in_valid & in_ready;

    // State register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: leave SEND only on a last-bit transfer with no new word.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = SEND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SEND: begin
                if (xfer_s && last_s && !accept_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = SEND;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Output decode from registered state; flags are combinational by design.
    always_comb begin
        in_ready     = 1'b1;
        out_valid    = 1'b0;
        out_bit      = 1'b0;
        out_first    = 1'b0;
        out_last     = 1'b0;
        exp_div_by_3 = 1'b0;
        exp_div_by_5 = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
            end
            SEND: begin
                out_valid    = 1'b1;
                out_bit      = bit_s;
                out_first    = first_s;
                out_last     = last_s;
                exp_div_by_3 = (r3_next_s == 2'd0);
                exp_div_by_5 = (r5_next_s == 3'd0);
                in_ready     = last_s & out_ready;
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

    // Word, bit index and running remainders; everything holds during a stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r <= {W{1'b0}};
            idx_r  <= {IW{1'b0}};
            r3_r   <= 2'd0;
            r5_r   <= 3'd0;
        end else if (accept_s) begin
            word_r <= in_data;
            idx_r  <= IDX_TOP;
            r3_r   <= 2'd0;
            r5_r   <= 3'd0;
        end else if (xfer_s) begin
            r3_r <= r3_next_s;
            r5_r <= r5_next_s;
            // Park the index at 0 after the last bit so it never points past the word.
            if (last_s) begin
                idx_r <= {IW{1'b0}};
            end else begin
                idx_r <= idx_r - IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_serial_number_transmitter.sv
// Self-checking bench for serial_number_transmitter (W = 16).
// A word-level reference model predicts every output each cycle from the
// accepted words and the integer value of the prefix sent so far; a second
// model rebuilds the prefix from the observed bit stream. Directed table
// vectors and hand-written sequences cover stalls, back-to-back words and
// asynchronous reset.
module tb_serial_number_transmitter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic        out_bit;
    logic        out_ready;
    logic        out_first;
    logic        out_last;
    logic        exp_div_by_3;
    logic        exp_div_by_5;

    serial_number_transmitter #(.W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_bit      (out_bit),
        .out_ready    (out_ready),
        .out_first    (out_first),
        .out_last     (out_last),
        .exp_div_by_3 (exp_div_by_3),
        .exp_div_by_5 (exp_div_by_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Predictive model state
    logic        m_active;
    logic [15:0] m_word;
    int          m_pos;
    int unsigned m_prefix;
    int          m_accepts;

    // Observed-stream model (prefix modulo 15 rebuilt from out_bit/out_first)
    int unsigned obs;

    // Outputs sampled in the last cycle
    logic s_ready, s_valid, s_bit, s_first, s_last, s_e3, s_e5;

    typedef struct {
        logic [15:0] word;
        logic [15:0] m3;
        logic [15:0] m5;
        int          stall_idx;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check all outputs against the model, clock, update the model.
    task automatic cycle(input logic iv, input logic [15:0] id, input logic ordy);
        logic        e_bit, e_first, e_last, e3, e5, e_ready;
        int unsigned pn;
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        s_ready = in_ready;  s_valid = out_valid; s_bit = out_bit;
        s_first = out_first; s_last = out_last;
        s_e3 = exp_div_by_3; s_e5 = exp_div_by_5;
        e_bit   = m_active ? m_word[m_pos] : 1'b0;
        e_first = m_active && (m_pos == 15);
        e_last  = m_active && (m_pos == 0);
        pn      = m_prefix * 2 + 32'(e_bit);
        e3      = m_active && (pn % 3 == 0);
        e5      = m_active && (pn % 5 == 0);
        e_ready = !m_active || (e_last && ordy);
        check("outputs", {s_ready, s_valid, s_bit, s_first, s_last, s_e3, s_e5},
              {e_ready, m_active, e_bit, e_first, e_last, e3, e5});
        if (out_valid && ordy) begin
            if (out_first) obs = 0;
            obs = (obs * 2 + 32'(out_bit)) % 15;
            check("ref_mod", {exp_div_by_3, exp_div_by_5}, {(obs % 3) == 0, (obs % 5) == 0});
        end
        @(posedge clk);
        if (m_active && ordy) begin
            m_prefix = pn;
            if (m_pos == 0) m_active = 1'b0;
            else m_pos--;
        end
        if (iv && e_ready) begin
            m_active = 1'b1;
            m_word   = id;
            m_pos    = 15;
            m_prefix = 0;
            m_accepts++;
        end
    endtask

    initial begin
        int          n;
        logic        ordy;
        int          run;
        logic        gap;
        logic        broken;
        int          start_acc;
        int          guard;

        vecs[0] = '{word: 16'h0005, m3: 16'hFFF8, m5: 16'hFFF9, stall_idx: -1};
        vecs[1] = '{word: 16'h000F, m3: 16'hFFF5, m5: 16'hFFF1, stall_idx: -1};
        vecs[2] = '{word: 16'hA5C3, m3: 16'h017D, m5: 16'h3901, stall_idx: 8};

        m_active = 1'b0; m_word = 16'h0000; m_pos = 0; m_prefix = 0; m_accepts = 0; obs = 0;
        rst = 1'b1; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_state", {in_ready, out_valid, out_first, out_last, exp_div_by_3, exp_div_by_5},
              6'b100000);
        @(negedge clk);
        rst = 1'b0;

        // Directed words with per-bit expected flags, one with a 3-cycle stall at index 8
        for (int v = 0; v < 3; v++) begin
            cycle(1'b1, vecs[v].word, 1'b1);
            for (int i = 15; i >= 0; i--) begin
                n = (i == vecs[v].stall_idx) ? 4 : 1;
                for (int s = 0; s < n; s++) begin
                    ordy = (s == n - 1);
                    cycle(1'b0, 16'($urandom), ordy);
                    check("tbl", {s_ready, s_valid, s_bit, s_first, s_last, s_e3, s_e5},
                          {((i == 0) && ordy), 1'b1, vecs[v].word[i], (i == 15), (i == 0),
                           vecs[v].m3[i], vecs[v].m5[i]});
                end
            end
        end

        // Back-to-back words with in_valid held: 0x0003 then 0x0006
        cycle(1'b1, 16'h0003, 1'b1);
        run = 0; gap = 1'b0; broken = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            cycle((c <= 16), 16'h0006, 1'b1);
            if (s_valid) begin
                if (gap) broken = 1'b1;
                run++;
            end else begin
                gap = (run > 0);
            end
            if (c == 1 || c == 17) check("b2b_first", s_first, 1'b1);
            if (c == 16 || c == 32) check("b2b_div3", s_e3, 1'b1);
        end
        check("b2b_len", run, 32);
        check("b2b_gap", broken, 1'b0);

        // Asynchronous reset while bit index 7 is presented
        cycle(1'b1, 16'hFFFF, 1'b1);
        for (int i = 15; i >= 8; i--) cycle(1'b0, 16'h0000, 1'b1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        #2;
        check("pre_rst_valid", out_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_ready", in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        m_active = 1'b0; m_prefix = 0; m_pos = 0;
        cycle(1'b1, 16'h0001, 1'b1);
        for (int i = 15; i >= 0; i--) begin
            cycle(1'b0, 16'($urandom), 1'b1);
            if (i == 15) check("rst_word_first", s_first, 1'b1);
            if (i == 0) check("rst_word_last", {s_last, s_e3, s_e5}, 3'b100);
        end

        // 1000 random words with random out_ready
        start_acc = m_accepts;
        guard = 0;
        while ((m_accepts - start_acc) < 1000 && guard < 60000) begin
            cycle(($urandom_range(0, 3) != 0), 16'($urandom), ($urandom_range(0, 3) != 0));
            guard++;
        end
        check("rand_words", m_accepts - start_acc, 1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_number_transmitter.md
SERIAL_NUMBER_TRANSMITTER -- requirements
Module: serial_number_transmitter

Interface
REQ-001 SHALL have parameter W, default 16, meaning word width in bits; legal range W >= 1.
REQ-002 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  parallel word offered.
REQ-005 SHALL have port in_data  input  W  word to serialize, unsigned.
REQ-006 SHALL have port in_ready  output  1  word accepted when in_valid & in_ready at clk edge.
REQ-007 SHALL have port out_valid  output  1  out_bit holds a valid serial bit.
REQ-008 SHALL have port out_bit  output  1  current serial bit, MSB first.
REQ-009 SHALL have port out_ready  input  1  bit transferred when out_valid & out_ready at clk edge.
REQ-010 SHALL have port out_first  output  1  current bit is the word's MSB; downstream checker clears its remainder.
REQ-011 SHALL have port out_last  output  1  current bit is the word's LSB.
REQ-012 SHALL have port exp_div_by_3  output  1  prefix of the word up to and including out_bit is divisible by 3.
REQ-013 SHALL have port exp_div_by_5  output  1  prefix of the word up to and including out_bit is divisible by 5.

Function
REQ-014 SHALL implement a two-state FSM: IDLE (no word held) and SEND (word being shifted out).
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid, out_first, out_last, exp_div_by_3 and exp_div_by_5 SHALL be 0.
REQ-016 On acceptance in IDLE, the block SHALL load in_data, set the bit index to W-1 and the stored remainders r3 and r5 to 0, then enter SEND the next cycle.
REQ-017 In SEND, out_valid SHALL be 1 and out_bit SHALL equal the stored word bit at the current index, so MSB (bit W-1) goes first.
REQ-018 out_first SHALL be 1 only when the index is W-1; out_last SHALL be 1 only when the index is 0; both SHALL be 1 when W = 1.
REQ-019 exp_div_by_3 SHALL equal ((2*r3 + out_bit) mod 3 == 0) and exp_div_by_5 SHALL equal ((2*r5 + out_bit) mod 5 == 0), both combinational from registered state.
REQ-020 On each transfer, r3 SHALL update to (2*r3 + out_bit) mod 3, r5 SHALL update to (2*r5 + out_bit) mod 5, and the index SHALL decrement by 1.
REQ-021 r3 SHALL be 2 bits wide and r5 SHALL be 3 bits wide; each SHALL always be in range (r3 in 0..2, r5 in 0..4).
REQ-022 While out_valid = 1 and out_ready = 0, out_bit, out_first, out_last, the exp flags and all internal state SHALL hold unchanged for any number of stall cycles.
REQ-023 in_ready SHALL be 1 in IDLE, or in SEND when out_last = 1 and out_ready = 1; in_ready SHALL be 0 otherwise.
REQ-024 On a last-bit transfer with no simultaneous acceptance, the FSM SHALL return to IDLE the next cycle.
REQ-025 A last-bit transfer with simultaneous acceptance SHALL load the new word with r3 = r5 = 0 and stay in SEND, so out_first = 1 the next cycle with no bubble.
REQ-026 Transfer latency SHALL be one cycle from acceptance to the first out_valid; an unstalled word SHALL occupy exactly W consecutive out_valid cycles.
REQ-027 in_data SHALL be sampled only at acceptance; in_data changes during SEND SHALL have no effect.

Reset
REQ-028 Asserting rst SHALL immediately force IDLE, index 0, r3 = 0, r5 = 0, stored word 0, and out_valid = 0, independent of clk.
REQ-029 Reset mid-word SHALL discard the partial word; after release, in_ready = 1 and the next accepted word SHALL begin with out_first = 1.

Verification
REQ-030 Bench SHALL send W=16 word 16'h0005 with out_ready=1 -> 16 bits 0x13,1,0,1; exp_div_by_3/5 SHALL be 1/1 on the 13 zero bits, then 0/0, 0/0, 0/1; out_last = 1 only on the final bit.
REQ-031 Bench SHALL send 16'h000F -> final bit shows exp_div_by_3 = 1 and exp_div_by_5 = 1 (value 15), and the preceding bit shows 0/0 (value 7).
REQ-032 Bench SHALL drop out_ready for 3 cycles at bit index 8 of 16'hA5C3 -> out_bit, flags and in_ready SHALL be constant throughout the stall, and the sequence SHALL resume unchanged.
REQ-033 Bench SHALL hold in_valid = 1 with 16'h0003 then 16'h0006 -> exactly 32 consecutive out_valid cycles, out_first on cycles 1 and 17, exp_div_by_3 = 1 on cycles 16 and 32.
REQ-034 Bench SHALL assert rst asynchronously between edges while bit index 7 is presented -> out_valid SHALL go to 0 before the next edge; after release, a new word 16'h0001 SHALL give a final bit with both flags 0.
REQ-035 Bench SHALL run 1000 random words with random out_ready, feeding out_bit/out_first into a reference mod-3/mod-5 model -> every transfer SHALL match exp_div_by_3 and exp_div_by_5.
